oem8_sort_pipe: RTL

//  Parametrised, fully pipelined 8-input Batcher odd-even merge sorter. It replaces the

---
 rtl/oem8_sort_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/oem8_sort_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oem8_sort_pipe : 8-lane Batcher odd-even merge sorter, 6 registered layers,|
// |                  per-beat asc/desc mode, valid/ready with global stall.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module oem8_sort_pipe #(
  parameter int DW     = 6,
  parameter bit STABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_desc,
  input  logic [8*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_desc,
  output logic [8*DW-1:0] out_data,
  output logic            busy
);

  localparam int c_nstage = 6;

  typedef logic [7:0][DW-1:0] beat_t;

  // Compare-exchange: lower key to lane i in ascending mode, higher key in descending.
  function automatic beat_t ce(input beat_t x, input logic [2:0] i, input logic [2:0] j,
                               input logic desc);
    beat_t y;
    logic  sw;
    if (STABLE) sw = desc ? (x[i] < x[j]) : (x[i] > x[j]);
    else        sw = (x[i] > x[j]) ^ desc;
    y = x;
    if (sw) begin
      y[i] = x[j];
      y[j] = x[i];
    end
    return y;
  endfunction

  function automatic beat_t layer(input beat_t x, input logic [2:0] l, input logic desc);
    beat_t y;
    y = x;
    case (l)
      3'd1: begin
        y = ce(y, 3'd0, 3'd1, desc); y = ce(y, 3'd2, 3'd3, desc);
        y = ce(y, 3'd4, 3'd5, desc); y = ce(y, 3'd6, 3'd7, desc);
      end
      3'd2: begin
        y = ce(y, 3'd0, 3'd2, desc); y = ce(y, 3'd1, 3'd3, desc);
        y = ce(y, 3'd4, 3'd6, desc); y = ce(y, 3'd5, 3'd7, desc);
      end
      3'd3: begin
        y = ce(y, 3'd1, 3'd2, desc); y = ce(y, 3'd5, 3'd6, desc);
      end
      3'd4: begin
        y = ce(y, 3'd0, 3'd4, desc); y = ce(y, 3'd1, 3'd5, desc);
        y = ce(y, 3'd2, 3'd6, desc); y = ce(y, 3'd3, 3'd7, desc);
      end
      3'd5: begin
        y = ce(y, 3'd2, 3'd4, desc); y = ce(y, 3'd3, 3'd5, desc);
      end
      3'd6: begin
        y = ce(y, 3'd1, 3'd2, desc); y = ce(y, 3'd3, 3'd4, desc);
        y = ce(y, 3'd5, 3'd6, desc);
      end
      default: y = x;
    endcase
    return y;
  endfunction

  beat_t               r_d [c_nstage];
  logic [c_nstage-1:0] r_v;
  logic [c_nstage-1:0] r_m;
  beat_t               w_n [c_nstage];
  logic                w_stall;

  generate
    for (genvar s = 0; s < c_nstage; s++) begin : g_layer
      if (s == 0) begin : g_first
        assign w_n[s] = layer(beat_t'(in_data), 3'(s + 1), in_desc);
      end else begin : g_rest
        assign w_n[s] = layer(r_d[s-1], 3'(s + 1), r_m[s-1]);
      end
    end
  endgenerate

  assign w_stall = r_v[c_nstage-1] && !out_ready;

  // Mode bits shift alongside data so each stage compares with its own beat's mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_m <= '0;
      for (int s = 0; s < c_nstage; s++) r_d[s] <= '0;
    end else if (!w_stall) begin
      r_v <= {r_v[c_nstage-2:0], in_valid};
      r_m <= {r_m[c_nstage-2:0], in_desc};
      for (int s = 0; s < c_nstage; s++) r_d[s] <= w_n[s];
    end
  end

  assign in_ready  = !w_stall;
  assign out_valid = r_v[c_nstage-1];
  assign out_desc  = r_m[c_nstage-1];
  assign out_data  = r_d[c_nstage-1];
  assign busy      = |r_v;

endmodule
`default_nettype wire
